input_event_fifo: RTL and testbench



---
 rtl/input_event_fifo.sv | 189 ++++++++++++++++++
 tb/tb_input_event_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_event_fifo.sv
// Frame-sampled input change capture: each sample strobe snapshots every channel,
// scans them one per cycle and queues an event per changed channel in a FWFT FIFO.
// Optional: define INPUT_EVENT_TIMESTAMP_EN to prefix each event with a 16-bit frame stamp.

module input_event_lane #(
  parameter int WIDTH = 32
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             commit_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] cur_o,
  output logic             chg_o
);
  logic [WIDTH-1:0] cur_q, prev_q;

  // load (IDLE) and commit (SCAN) are never active together
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cur_q  <= '0;
      prev_q <= '0;
    end else begin
      if (load_i)   cur_q  <= d_i;
      if (commit_i) prev_q <= cur_q;
    end
  end

  assign cur_o = cur_q;
  assign chg_o = (cur_q != prev_q);
endmodule

module input_event_fifo #(
  parameter int CHANNELS = 6,
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
`ifdef INPUT_EVENT_TIMESTAMP_EN
  parameter int EW       = CW + WIDTH + 16
`else
  parameter int EW       = CW + WIDTH
`endif
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      sample,
  input  logic                      rd,
  input  logic                      clr_ovf,
  output logic [EW-1:0]             dout,
  output logic                      empty,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      busy,
  output logic                      overflow,
  output logic                      missed
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SCAN} state_t;

  typedef struct packed {
`ifdef INPUT_EVENT_TIMESTAMP_EN
    logic [15:0]      ts;
`endif
    logic [CW-1:0]    chan;
    logic [WIDTH-1:0] state;
  } entry_t;

  state_t        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          accept, scan_en;

  logic [CHANNELS-1:0][WIDTH-1:0] lane_cur;
  logic [CHANNELS-1:0]            lane_chg;

  entry_t        mem_q [DEPTH];
  entry_t        new_entry;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, missed_q;
  logic          push_req, do_push, do_rd, drop, full_w, empty_w;

`ifdef INPUT_EVENT_TIMESTAMP_EN
  logic [15:0]   ts_q;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    scan_en = 1'b0;
    case (state_q)
      IDLE: if (sample) begin
        accept  = 1'b1;
        idx_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        scan_en = 1'b1;
        if (idx_q == CW'(CHANNELS-1)) state_d = IDLE;
        else                          idx_d   = CW'(idx_q + 1'b1);
      end
      default: state_d = IDLE;
    endcase
  end

  // prev of a channel is committed in its scan slot whether or not the push lands
  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    input_event_lane #(.WIDTH(WIDTH)) u_lane (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .load_i   (accept),
      .commit_i (scan_en && (idx_q == CW'(k))),
      .d_i      (in_data[k*WIDTH +: WIDTH]),
      .cur_o    (lane_cur[k]),
      .chg_o    (lane_chg[k])
    );
  end

`ifdef INPUT_EVENT_TIMESTAMP_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)    ts_q <= '0;
    else if (accept) ts_q <= ts_q + 16'd1;
  end
`endif

  always_comb begin
    new_entry       = '0;
`ifdef INPUT_EVENT_TIMESTAMP_EN
    new_entry.ts    = ts_q;
`endif
    new_entry.chan  = idx_q;
    new_entry.state = lane_cur[idx_q];
  end

  assign full_w   = (count_q == (AW+1)'(DEPTH));
  assign empty_w  = (count_q == '0);
  assign push_req = scan_en && lane_chg[idx_q];
  assign do_rd    = rd && !empty_w;
  // a same-cycle pop frees the slot a full-FIFO push needs
  assign do_push  = push_req && (!full_w || do_rd);
  assign drop     = push_req && full_w && !do_rd;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_rd)      count_d = count_q + 1'b1;
    else if (!do_push && do_rd) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wr_ptr_q] <= new_entry;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_d;
      ovf_q    <= drop | (ovf_q & ~clr_ovf);
      missed_q <= (sample && (state_q == SCAN)) | (missed_q & ~clr_ovf);
    end
  end

  // masked so the head reads 0 out of reset even though storage is not reset
  assign dout     = empty_w ? '0 : mem_q[rd_ptr_q];
  assign empty    = empty_w;
  assign full     = full_w;
  assign count    = count_q;
  assign busy     = (state_q == SCAN);
  assign overflow = ovf_q;
  assign missed   = missed_q;
endmodule

// File: tb/tb_input_event_fifo.sv
// Bench for input_event_fifo: directed table, corner sequences and random traffic
// checked against a queue-based event model.
module tb_input_event_fifo;
  localparam int CH = 6;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = 3;
`ifdef INPUT_EVENT_TIMESTAMP_EN
  localparam int EW = CW + W + 16;
`else
  localparam int EW = CW + W;
`endif

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic [CH*W-1:0]   in_data = '0;
  logic              sample = 1'b0, rd = 1'b0, clr_ovf = 1'b0;
  logic [EW-1:0]     dout;
  logic              empty, full, busy, overflow, missed;
  logic [2:0]        count;

  always #5 clk_sys = ~clk_sys;

  input_event_fifo #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .in_data(in_data), .sample(sample),
    .rd(rd), .clr_ovf(clr_ovf), .dout(dout), .empty(empty), .full(full),
    .count(count), .busy(busy), .overflow(overflow), .missed(missed)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: event queue plus snapshot arrays
  logic [W-1:0]  m_cur [CH];
  logic [W-1:0]  m_prev[CH];
  logic [63:0]   q[$];
  bit            m_scan, m_ovf, m_mis;
  int            m_idx;
  logic [15:0]   m_ts;

  function automatic logic [63:0] mk(logic [15:0] ts, int ch, logic [W-1:0] st);
    logic [CW-1:0] c;
    c = ch[CW-1:0];
`ifdef INPUT_EVENT_TIMESTAMP_EN
    return {13'd0, ts, c, st};
`else
    return {29'd0, c, st};
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin m_cur[k] = '0; m_prev[k] = '0; end
    q.delete();
    m_scan = 0; m_ovf = 0; m_mis = 0; m_idx = 0; m_ts = '0;
  endtask

  task automatic model_step(bit s, bit r, bit c, logic [CH*W-1:0] d);
    bit push = 0, drop = 0;
    logic [63:0] e = '0;
    if (m_scan) begin
      if (m_cur[m_idx] != m_prev[m_idx]) begin
        push = 1;
        e = mk(m_ts, m_idx, m_cur[m_idx]);
      end
      m_prev[m_idx] = m_cur[m_idx];
    end
    if (r && q.size() > 0) void'(q.pop_front());
    if (push) begin
      if (q.size() < D) q.push_back(e);
      else drop = 1;
    end
    m_ovf = drop || (m_ovf && !c);
    m_mis = (s && m_scan) || (m_mis && !c);
    if (m_scan) begin
      if (m_idx == CH-1) m_scan = 0;
      else m_idx++;
    end else if (s) begin
      for (int k = 0; k < CH; k++) m_cur[k] = d[k*W +: W];
      m_idx = 0; m_scan = 1; m_ts++;
    end
  endtask

  task automatic check_model();
    chk("busy", 64'(busy), 64'(m_scan));
    chk("count", 64'(count), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("full", 64'(full), 64'(q.size() == D));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("missed", 64'(missed), 64'(m_mis));
    if (q.size() > 0) chk("dout", 64'(dout), q[0]);
  endtask

  // one clock: drive at negedge, sample results at the following negedge
  task automatic cyc(bit s, bit r, bit c, logic [CH*W-1:0] d);
    sample = s; rd = r; clr_ovf = c; in_data = d;
    model_step(s, r, c, d);
    @(posedge clk_sys);
    @(negedge clk_sys);
    sample = 0; rd = 0; clr_ovf = 0;
    check_model();
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    #2;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_missed", 64'(missed), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    model_reset();
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit          s;
    bit          r;
    logic [W-1:0] ch2;
    bit          e_busy;
    int          e_cnt;
    logic [15:0] e_ts;
  } vec_t;

  initial begin
    vec_t tbl[$];
    logic [CH*W-1:0] d, d2;
    logic [W-1:0]    vals[CH];

    model_reset();
    @(negedge clk_sys);
    do_reset();

    // all-zero frame, then channel 2 = 0x10, then a repeat with no change
    tbl.push_back('{1, 0, 32'h0, 1, 0, 16'd0});
    repeat (5) tbl.push_back('{0, 0, 32'h0, 1, 0, 16'd0});
    tbl.push_back('{0, 0, 32'h0, 0, 0, 16'd0});
    tbl.push_back('{1, 0, 32'h10, 1, 0, 16'd0});
    repeat (2) tbl.push_back('{0, 0, 32'h10, 1, 0, 16'd0});
    repeat (3) tbl.push_back('{0, 0, 32'h10, 1, 1, 16'd2});
    tbl.push_back('{0, 0, 32'h10, 0, 1, 16'd2});
    tbl.push_back('{1, 0, 32'h10, 1, 1, 16'd2});
    repeat (5) tbl.push_back('{0, 0, 32'h10, 1, 1, 16'd2});
    tbl.push_back('{0, 0, 32'h10, 0, 1, 16'd2});
    tbl.push_back('{0, 1, 32'h10, 0, 0, 16'd2});
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].s, tbl[i].r, 1'b0, {{(3*W){1'b0}}, tbl[i].ch2, {(2*W){1'b0}}});
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_empty", i), 64'(empty), 64'(tbl[i].e_cnt == 0));
      if (tbl[i].e_cnt > 0)
        chk($sformatf("tbl%0d_head", i), 64'(dout), mk(tbl[i].e_ts, 2, 32'h10));
    end

    // overflow: six changes into a four-deep FIFO, then clear
    do_reset();
    for (int k = 0; k < CH; k++) begin
      vals[k] = 32'hA000_0000 + 32'(k + 1);
      d[k*W +: W] = vals[k];
    end
    cyc(1, 0, 0, d);
    repeat (7) cyc(0, 0, 0, d);
    chk("ovf_count", 64'(count), 64'd4);
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_flag", 64'(overflow), 64'd1);
    cyc(0, 0, 1, d);
    chk("ovf_clr", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_chan%0d", i), 64'(dout[W +: CW]), 64'(i));
      chk($sformatf("ovf_state%0d", i), 64'(dout[W-1:0]), 64'(vals[i]));
      cyc(0, 1, 0, d);
    end

    // full FIFO with rd in the cycle channel 4 is pushed
    do_reset();
    cyc(1, 0, 0, d);
    repeat (4) cyc(0, 0, 0, d);
    cyc(0, 1, 0, d);
    chk("fullrd_count", 64'(count), 64'd4);
    chk("fullrd_ovf", 64'(overflow), 64'd0);
    cyc(0, 0, 0, d);
    chk("fullrd_ch5_drop", 64'(overflow), 64'd1);
    repeat (4) cyc(0, 1, 1, d);

    // sample two cycles into a scan is ignored
    do_reset();
    d = '0;
    d[0*W +: W] = 32'h1; d[3*W +: W] = 32'h33; d[5*W +: W] = 32'h55;
    d2 = '1;
    cyc(1, 0, 0, d);
    cyc(0, 0, 0, d);
    cyc(1, 0, 0, d2);
    repeat (6) cyc(0, 0, 0, d2);
    chk("miss_flag", 64'(missed), 64'd1);
    chk("miss_count", 64'(count), 64'd3);
    cyc(0, 0, 1, d2);
    chk("miss_clr", 64'(missed), 64'd0);

    // reset mid-scan, then every nonzero channel is reported again
    do_reset();
    d = '0;
    d[1*W +: W] = 32'h11; d[2*W +: W] = 32'h22; d[4*W +: W] = 32'h44;
    cyc(1, 0, 0, d);
    cyc(0, 0, 0, d);
    cyc(0, 0, 0, d);
    do_reset();
    cyc(1, 0, 0, d);
    repeat (7) cyc(0, 0, 0, d);
    chk("rerep_count", 64'(count), 64'd3);

    // third accepted frame changes channel 0
    do_reset();
    d = '0;
    cyc(1, 0, 0, d);
    repeat (6) cyc(0, 0, 0, d);
    cyc(1, 0, 0, d);
    repeat (6) cyc(0, 0, 0, d);
    d[0 +: W] = 32'h5;
    cyc(1, 0, 0, d);
    repeat (6) cyc(0, 0, 0, d);
    chk("ts_count", 64'(count), 64'd1);
    chk("ts_chan", 64'(dout[W +: CW]), 64'd0);
`ifdef INPUT_EVENT_TIMESTAMP_EN
    chk("ts_value", 64'(dout[EW-1 -: 16]), 64'd3);
`endif

    // random traffic
    do_reset();
    d = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < CH; k++)
        if ($urandom_range(0, 5) == 0) d[k*W +: W] = 32'($urandom_range(0, 3));
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 19) == 0, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
